param_adder_engine: RTL and testbench

- Parametrised, queued arithmetic engine; successor to the single-shot 8-bit adder.
- Accepts strobed requests {a, b, mode} into an input FIFO and executes them one at a time through a LATENCY-cycle compute stage.
- Returns each result with a one-cycle ack pulse.
- Adds subtract, multiply-accumulate and accumulator-clear modes, overflow reporting, and backpressure/drop reporting.
- Sits behind the TB/RTL interface, replacing the fixed adder DUT.

---
 rtl/param_adder_engine_if.sv | 43 ++++
 rtl/param_adder_engine.sv | 231 +++++++++++++++++++++++
 tb/tb_param_adder_engine.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/param_adder_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : param_adder_engine_if
// Description : Request/response bundle for param_adder_engine.
//               Request side : en, a, b, mode  (driven by the master)
//               Response side: full, pending, out, ack, ovf, drop
//                              (driven by the engine, the slave)
// Revision    : 1.0 - initial release
// ============================================================================
interface param_adder_engine_if #(
  parameter int IN_W       = 8,
  parameter int OUT_W      = 16,
  parameter int FIFO_DEPTH = 4
) ();

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // request side
  logic             en;       // request strobe, sampled every rising edge
  logic [IN_W-1:0]  a;        // operand A, unsigned
  logic [IN_W-1:0]  b;        // operand B, unsigned
  logic [1:0]       mode;     // 00 add, 01 sub, 10 mac, 11 clear acc

  // response / status side
  logic             full;     // queue holds FIFO_DEPTH entries
  logic [CNT_W-1:0] pending;  // queued requests, excluding the in-flight one
  logic [OUT_W-1:0] out;      // last completed result, held until next ack
  logic             ack;      // one-cycle completion pulse
  logic             ovf;      // overflow of last completed operation
  logic             drop;     // sticky: a request was rejected

  modport master (
    output en, a, b, mode,
    input  full, pending, out, ack, ovf, drop
  );

  modport slave (
    input  en, a, b, mode,
    output full, pending, out, ack, ovf, drop
  );

endinterface
`default_nettype wire

// File: rtl/param_adder_engine.sv
`default_nettype none
// ============================================================================
// Module      : param_adder_engine
// Description : Queued arithmetic engine. Strobed requests {a, b, mode} are
//               captured into a FIFO and executed one at a time through a
//               LATENCY-cycle compute stage. Each result is announced with a
//               one-cycle ack pulse; out/ovf hold until the next ack.
//               Modes: add, sub, multiply-accumulate, accumulator clear.
// Ports       : clk   - single clock, rising edge
//               reset - synchronous, active-high
//               bus   - param_adder_engine_if.slave (request + status)
// Revision    : 1.0 - initial release
// ============================================================================
module param_adder_engine #(
  parameter int IN_W       = 8,   // operand width, >= 2
  parameter int OUT_W      = 16,  // result/accumulator width, >= IN_W+1
  parameter int FIFO_DEPTH = 4,   // queue depth, power of two, >= 2
  parameter int LATENCY    = 2    // compute cycles per operation, >= 1
) (
  input  wire logic          clk,
  input  wire logic          reset,
  param_adder_engine_if.slave bus
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int LAT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int ENTRY_W = 2 * IN_W + 2;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_MAC = 2'b10;
  localparam logic [1:0] MODE_CLR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Request FIFO
  // --------------------------------------------------------------------------
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;
  logic               full_q;
  logic               drop_q;

  logic               push;
  logic               reject;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  // full is the registered flag from before the edge, so a request arriving
  // while full is rejected even if the FSM pops on that same edge.
  assign push   = bus.en &  ~full_q;
  assign reject = bus.en &   full_q;
  assign head   = fifo_mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage carries no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {bus.mode, bus.b, bus.a};
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count  <= count_nxt;
      full_q <= (count_nxt == CNT_W'(FIFO_DEPTH));
      if (reject) begin
        drop_q <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  state_t           state;
  state_t           state_nxt;
  logic [LAT_W-1:0] cnt;
  logic             finish;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand registers and arithmetic
  // --------------------------------------------------------------------------
  logic [IN_W-1:0]  op_a;
  logic [IN_W-1:0]  op_b;
  logic [1:0]       op_mode;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] out_q;
  logic             ovf_q;
  logic             ack_q;

  logic [OUT_W-1:0] a_ext;
  logic [OUT_W-1:0] b_ext;
  logic [OUT_W-1:0] add_res;
  logic [OUT_W-1:0] sub_res;
  logic [OUT_W-1:0] prod;
  logic [OUT_W:0]   mac_sum;

  assign a_ext   = {{(OUT_W - IN_W){1'b0}}, op_a};
  assign b_ext   = {{(OUT_W - IN_W){1'b0}}, op_b};
  assign add_res = a_ext + b_ext;
  // Two's-complement wrap gives the negative result when a < b.
  assign sub_res = a_ext - b_ext;
  assign prod    = a_ext * b_ext;
  // Extra top bit captures the carry out of the accumulator MSB.
  assign mac_sum = {1'b0, acc} + {1'b0, prod};

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      op_mode <= MODE_ADD;
      acc     <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= finish;

      if (pop) begin
        {op_mode, op_b, op_a} <= head;
        cnt                   <= LAT_W'(LATENCY - 1);
      end else if ((state == EXEC) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end

      if (finish) begin
        case (op_mode)
          MODE_ADD: begin
            out_q <= add_res;
            ovf_q <= 1'b0;
          end
          MODE_SUB: begin
            out_q <= sub_res;
            ovf_q <= 1'b0;
          end
          MODE_MAC: begin
            acc   <= mac_sum[OUT_W-1:0];
            out_q <= mac_sum[OUT_W-1:0];
            ovf_q <= mac_sum[OUT_W];
          end
          MODE_CLR: begin
            acc   <= '0;
            out_q <= '0;
            ovf_q <= 1'b0;
          end
          default: begin
            out_q <= '0;
            ovf_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.full    = full_q;
  assign bus.pending = count;
  assign bus.out     = out_q;
  assign bus.ack     = ack_q;
  assign bus.ovf     = ovf_q;
  assign bus.drop    = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_param_adder_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_adder_engine
// Description : Directed, self-checking bench for param_adder_engine with
//               hand-computed expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_adder_engine;

  localparam int IN_W       = 8;
  localparam int OUT_W      = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int LATENCY    = 2;

  localparam logic [1:0] M_ADD = 2'b00;
  localparam logic [1:0] M_SUB = 2'b01;
  localparam logic [1:0] M_MAC = 2'b10;
  localparam logic [1:0] M_CLR = 2'b11;

  logic clk;
  logic reset;

  param_adder_engine_if #(
    .IN_W       (IN_W),
    .OUT_W      (OUT_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) bus ();

  param_adder_engine #(
    .IN_W       (IN_W),
    .OUT_W      (OUT_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .LATENCY    (LATENCY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            tag;
    logic [OUT_W-1:0] out;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];
  int   total   = 0;
  int   bad     = 0;
  int   ack_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%0h) want=%0d (0x%0h)", tag, got, got,
               want, want);
    end
  endtask

  // Advance one edge and sample 1ns later; every ack is matched in order
  // against the expected-result queue.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.ack === 1'b1) begin
      ack_cnt++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq({e.tag, "_out"}, 32'(bus.out), 32'(e.out));
        check_eq({e.tag, "_ovf"}, 32'(bus.ovf), 32'(e.ovf));
      end else begin
        check_eq("spurious_ack", 32'(bus.ack), 32'd0);
      end
    end
  endtask

  task automatic expect_result(input string tag, input logic [OUT_W-1:0] eo,
                               input logic eov);
    exp_t e;
    e.tag = tag;
    e.out = eo;
    e.ovf = eov;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [1:0] m, input logic [IN_W-1:0] av,
                       input logic [IN_W-1:0] bv);
    bus.en   = 1'b1;
    bus.mode = m;
    bus.a    = av;
    bus.b    = bv;
  endtask

  task automatic do_op(input string tag, input logic [1:0] m,
                       input logic [IN_W-1:0] av, input logic [IN_W-1:0] bv,
                       input logic [OUT_W-1:0] eo, input logic eov);
    int n0;
    n0 = ack_cnt;
    expect_result(tag, eo, eov);
    drive(m, av, bv);
    step();
    bus.en = 1'b0;
    for (int i = 0; i < 20 && ack_cnt == n0; i++) step();
    check_eq({tag, "_acked"}, 32'(ack_cnt - n0), 32'd1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    reset    = 1'b1;
    bus.en   = 1'b0;
    bus.a    = '0;
    bus.b    = '0;
    bus.mode = M_ADD;
    step();
    step();
    reset = 1'b0;

    // ---- reset state
    check_eq("rst_out",     32'(bus.out),     32'd0);
    check_eq("rst_ack",     32'(bus.ack),     32'd0);
    check_eq("rst_ovf",     32'(bus.ovf),     32'd0);
    check_eq("rst_full",    32'(bus.full),    32'd0);
    check_eq("rst_pending", 32'(bus.pending), 32'd0);
    check_eq("rst_drop",    32'(bus.drop),    32'd0);

    // ---- 1: single add with cycle-exact ack timing
    expect_result("t1_add", 16'd8, 1'b0);
    drive(M_ADD, 8'd7, 8'd1);
    step();                                   // edge N: pushed
    bus.en = 1'b0;
    bus.a  = 8'd99;                           // must not affect queued entry
    check_eq("t1_ack_n",      32'(bus.ack),     32'd0);
    check_eq("t1_pending_n",  32'(bus.pending), 32'd1);
    step();                                   // edge N+1: popped
    check_eq("t1_ack_n1",     32'(bus.ack),     32'd0);
    check_eq("t1_pending_n1", 32'(bus.pending), 32'd0);
    step();                                   // edge N+2
    check_eq("t1_ack_n2",     32'(bus.ack),     32'd0);
    step();                                   // edge N+3: ack
    check_eq("t1_ack_n3",     32'(bus.ack),     32'd1);
    check_eq("t1_out_n3",     32'(bus.out),     32'd8);
    step();                                   // edge N+4
    check_eq("t1_ack_n4",     32'(bus.ack),     32'd0);
    check_eq("t1_out_held",   32'(bus.out),     32'd8);

    // ---- 2: subtract and wide add
    do_op("t2_sub", M_SUB, 8'd6,   8'd8,   16'hFFFE, 1'b0);
    do_op("t2_add", M_ADD, 8'd255, 8'd255, 16'd510,  1'b0);

    // ---- 3: multiply-accumulate and clear
    do_op("t3_mac1", M_MAC, 8'd71, 8'd23, 16'd1633, 1'b0);
    do_op("t3_mac2", M_MAC, 8'd14, 8'd11, 16'd1787, 1'b0);
    do_op("t3_clr",  M_CLR, 8'd3,  8'd4,  16'd0,    1'b0);
    do_op("t3_mac3", M_MAC, 8'd5,  8'd6,  16'd30,   1'b0);

    // ---- 4: accumulator overflow
    do_op("t4_clr",  M_CLR, 8'd0,   8'd0,   16'd0,     1'b0);
    do_op("t4_mac1", M_MAC, 8'd255, 8'd255, 16'd65025, 1'b0);
    do_op("t4_mac2", M_MAC, 8'd255, 8'd255, 16'd64514, 1'b1);
    // add/sub leave the accumulator alone
    do_op("t4_add",  M_ADD, 8'd1,   8'd2,   16'd3,     1'b0);
    do_op("t4_mac3", M_MAC, 8'd1,   8'd1,   16'd64515, 1'b0);

    // ---- 5: back-to-back pushes, full and drop
    n0 = ack_cnt;
    expect_result("t5_s0", 16'd3,   1'b0);
    expect_result("t5_s1", 16'd7,   1'b0);
    expect_result("t5_s2", 16'd30,  1'b0);
    expect_result("t5_s3", 16'd150, 1'b0);
    expect_result("t5_s4", 16'd300, 1'b0);
    drive(M_ADD, 8'd1, 8'd2);     step();
    drive(M_ADD, 8'd3, 8'd4);     step();
    drive(M_ADD, 8'd10, 8'd20);   step();
    drive(M_ADD, 8'd100, 8'd50);  step();
    drive(M_ADD, 8'd200, 8'd100); step();
    check_eq("t5_pending_peak", 32'(bus.pending), 32'd4);
    check_eq("t5_full",         32'(bus.full),    32'd1);
    check_eq("t5_drop_before",  32'(bus.drop),    32'd0);
    drive(M_ADD, 8'd7, 8'd7);     step();         // rejected
    bus.en = 1'b0;
    check_eq("t5_drop",         32'(bus.drop),    32'd1);
    check_eq("t5_pending_after",32'(bus.pending), 32'd3);
    check_eq("t5_full_after",   32'(bus.full),    32'd0);
    for (int i = 0; i < 60 && (ack_cnt - n0) < 5; i++) step();
    for (int i = 0; i < 10; i++) step();
    check_eq("t5_ack_count",    32'(ack_cnt - n0),    32'd5);
    check_eq("t5_queue_drained",32'(exp_q.size()),    32'd0);
    check_eq("t5_drop_sticky",  32'(bus.drop),        32'd1);

    // ---- 6: reset mid-operation
    n0 = ack_cnt;
    drive(M_ADD, 8'd11, 8'd12); step();   // pushed
    drive(M_ADD, 8'd13, 8'd14); step();   // first popped into EXEC
    drive(M_ADD, 8'd15, 8'd16); step();   // still in EXEC
    bus.en = 1'b0;
    reset  = 1'b1;
    step();
    reset  = 1'b0;
    check_eq("t6_ack",     32'(bus.ack),     32'd0);
    check_eq("t6_out",     32'(bus.out),     32'd0);
    check_eq("t6_pending", 32'(bus.pending), 32'd0);
    check_eq("t6_drop",    32'(bus.drop),    32'd0);
    check_eq("t6_full",    32'(bus.full),    32'd0);
    for (int i = 0; i < 12; i++) step();
    check_eq("t6_no_ack",  32'(ack_cnt - n0), 32'd0);
    do_op("t6_after", M_ADD, 8'd9, 8'd4, 16'd13, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
